data_bus_responder: RTL and testbench

DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

---
 rtl/data_bus_responder.sv | 172 +++++++++++++++++
 tb/tb_data_bus_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/data_bus_responder.sv
// Data-memory bus slave for a single-cycle core: word RAM plus a memory-mapped
// timer (CTRL/COUNT/COMPARE/STATUS). Reads are combinational and writes commit on clk.
module data_bus_responder #(
  parameter int          RAM_WORDS  = 256,
  parameter logic [31:0] TIMER_BASE = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        busWe,
  input  logic [2:0]  busFunct3,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWData,
  output logic [31:0] busRData,
  output logic        busErr,
  output logic        timerIrq
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0]   r_ram [RAM_WORDS];
  logic [2:0]    r_ctrl;
  logic [31:0]   r_count;
  logic [31:0]   r_compare;
  logic          r_status;

  logic          w_f3Valid;
  logic          w_isHalf;
  logic          w_isWord;
  logic          w_isRam;
  logic          w_isTimer;
  logic          w_misalign;
  logic [AW-1:0] w_wordIdx;
  logic [31:0]   w_ramWord;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_rdata;
  logic [3:0]    w_be;
  logic [31:0]   w_wdataRep;
  logic [31:0]   w_merged;
  logic          w_ramWe;
  logic          w_timerWe;
  logic          w_wrCtrl;
  logic          w_wrCount;
  logic          w_wrCompare;
  logic          w_wrStatus;
  logic          w_match;
  logic [31:0]   w_countNext;

  always_comb begin
    w_f3Valid = 1'b0;
    case (busFunct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3Valid = 1'b1;
      default:                                w_f3Valid = 1'b0;
    endcase
  end

  assign w_isHalf   = (busFunct3[1:0] == 2'b01);
  assign w_isWord   = (busFunct3 == 3'b010);
  assign w_isRam    = (busAddr < RAM_BYTES);
  assign w_isTimer  = (busAddr[31:4] == TIMER_BASE[31:4]);
  assign w_misalign = (w_isHalf && busAddr[0]) || (w_isWord && (busAddr[1:0] != 2'b00));

  // Timer registers are word-only; any other width faults
  assign busErr = !w_f3Valid || w_misalign || !(w_isRam || w_isTimer) ||
                  (w_isTimer && !w_isWord);

  assign w_wordIdx = busAddr[AW+1:2];
  assign w_ramWord = r_ram[w_wordIdx];

  always_comb begin
    w_byte = w_ramWord[7:0];
    case (busAddr[1:0])
      2'd0:    w_byte = w_ramWord[7:0];
      2'd1:    w_byte = w_ramWord[15:8];
      2'd2:    w_byte = w_ramWord[23:16];
      default: w_byte = w_ramWord[31:24];
    endcase
    w_half = busAddr[1] ? w_ramWord[31:16] : w_ramWord[15:0];
  end

  always_comb begin
    w_rdata = '0;
    if (!busErr) begin
      if (w_isTimer) begin
        case (busAddr[3:2])
          2'd0:    w_rdata = {29'b0, r_ctrl};
          2'd1:    w_rdata = r_count;
          2'd2:    w_rdata = r_compare;
          default: w_rdata = {31'b0, r_status};
        endcase
      end else begin
        case (busFunct3)
          3'b000:  w_rdata = {{24{w_byte[7]}}, w_byte};
          3'b100:  w_rdata = {24'b0, w_byte};
          3'b001:  w_rdata = {{16{w_half[15]}}, w_half};
          3'b101:  w_rdata = {16'b0, w_half};
          3'b010:  w_rdata = w_ramWord;
          default: w_rdata = '0;
        endcase
      end
    end
  end

  assign busRData = w_rdata;

  // Store data is replicated across lanes so the byte enables alone pick the target
  always_comb begin
    w_be       = 4'b1111;
    w_wdataRep = busWData;
    case (busFunct3[1:0])
      2'b00: begin
        w_be       = 4'b0001 << busAddr[1:0];
        w_wdataRep = {4{busWData[7:0]}};
      end
      2'b01: begin
        w_be       = busAddr[1] ? 4'b1100 : 4'b0011;
        w_wdataRep = {2{busWData[15:0]}};
      end
      default: begin
        w_be       = 4'b1111;
        w_wdataRep = busWData;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      w_merged[i*8 +: 8] = w_be[i] ? w_wdataRep[i*8 +: 8] : w_ramWord[i*8 +: 8];
    end
  end

  assign w_ramWe = busWe && !busErr && w_isRam && !reset;

  always_ff @(posedge clk) begin
    if (w_ramWe) begin
      r_ram[w_wordIdx] <= w_merged;
    end
  end

  assign w_timerWe   = busWe && !busErr && w_isTimer;
  assign w_wrCtrl    = w_timerWe && (busAddr[3:2] == 2'd0);
  assign w_wrCount   = w_timerWe && (busAddr[3:2] == 2'd1);
  assign w_wrCompare = w_timerWe && (busAddr[3:2] == 2'd2);
  assign w_wrStatus  = w_timerWe && (busAddr[3:2] == 2'd3);
  assign w_match     = r_ctrl[0] && (r_count == r_compare);

  // Software COUNT write beats both auto-reload and increment
  always_comb begin
    w_countNext = r_count;
    if (w_wrCount) begin
      w_countNext = busWData;
    end else if (r_ctrl[0]) begin
      w_countNext = (w_match && r_ctrl[1]) ? 32'd0 : r_count + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl    <= 3'b000;
      r_count   <= 32'd0;
      r_compare <= 32'hFFFF_FFFF;
      r_status  <= 1'b0;
    end else begin
      if (w_wrCtrl)    r_ctrl    <= busWData[2:0];
      if (w_wrCompare) r_compare <= busWData;
      r_count <= w_countNext;
      if (w_match)                       r_status <= 1'b1;
      else if (w_wrStatus && busWData[0]) r_status <= 1'b0;
    end
  end

  assign timerIrq = r_status && r_ctrl[2];

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed self-checking bench for data_bus_responder: load/store lanes, error
// cases, timer match/auto-reload/W1C priority and asynchronous reset behaviour.
module tb_data_bus_responder;

  localparam logic [2:0]  F_B   = 3'b000;
  localparam logic [2:0]  F_H   = 3'b001;
  localparam logic [2:0]  F_W   = 3'b010;
  localparam logic [2:0]  F_BU  = 3'b100;
  localparam logic [2:0]  F_HU  = 3'b101;
  localparam logic [2:0]  F_BAD = 3'b011;
  localparam logic [31:0] T_CTRL    = 32'h1000_0000;
  localparam logic [31:0] T_COUNT   = 32'h1000_0004;
  localparam logic [31:0] T_COMPARE = 32'h1000_0008;
  localparam logic [31:0] T_STATUS  = 32'h1000_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic        busWe;
  logic [2:0]  busFunct3;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [31:0] busRData;
  logic        busErr;
  logic        timerIrq;

  int checks   = 0;
  int failures = 0;

  data_bus_responder #(
    .RAM_WORDS (256),
    .TIMER_BASE(32'h1000_0000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .busWe    (busWe),
    .busFunct3(busFunct3),
    .busAddr  (busAddr),
    .busWData (busWData),
    .busRData (busRData),
    .busErr   (busErr),
    .timerIrq (timerIrq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive the bus and let the combinational outputs settle
  task automatic applyStimulus(input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] data);
    busWe     = we;
    busFunct3 = f3;
    busAddr   = addr;
    busWData  = data;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, f3, addr, data);
    tick();
    busWe = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] expData, input logic expErr);
    applyStimulus(1'b0, f3, addr, 32'h0);
    checkOutput(tag, busRData, expData);
    checkOutput({tag, ".err"}, {31'b0, busErr}, {31'b0, expErr});
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, F_W, 32'h0, 32'h0);

    // Timer state is visible combinationally while reset is held
    readCheck("rst.ctrl",    F_W, T_CTRL,    32'h0,         1'b0);
    readCheck("rst.count",   F_W, T_COUNT,   32'h0,         1'b0);
    readCheck("rst.compare", F_W, T_COMPARE, 32'hFFFF_FFFF, 1'b0);
    readCheck("rst.status",  F_W, T_STATUS,  32'h0,         1'b0);
    checkOutput("rst.irq", {31'b0, timerIrq}, 32'h0);
    tick();
    tick();
    reset = 1'b0;

    busWrite(F_W, 32'h10, 32'h8000_00F0);
    readCheck("lb",  F_B,  32'h10, 32'hFFFF_FFF0, 1'b0);
    readCheck("lbu", F_BU, 32'h10, 32'h0000_00F0, 1'b0);
    readCheck("lh",  F_H,  32'h12, 32'hFFFF_8000, 1'b0);
    readCheck("lhu", F_HU, 32'h12, 32'h0000_8000, 1'b0);
    readCheck("lw",  F_W,  32'h10, 32'h8000_00F0, 1'b0);

    busWrite(F_W, 32'h10, 32'h1122_3344);
    busWrite(F_B, 32'h13, 32'h1234_56AB);
    readCheck("sb.lw", F_W, 32'h10, 32'hAB22_3344, 1'b0);
    busWrite(F_H, 32'h10, 32'hCAFE_BEEF);
    readCheck("sh.lw",  F_W,  32'h10, 32'hAB22_BEEF, 1'b0);
    readCheck("lb.b1",  F_B,  32'h11, 32'hFFFF_FFBE, 1'b0);
    readCheck("lbu.b3", F_BU, 32'h13, 32'h0000_00AB, 1'b0);
    busWrite(F_W, 32'h20, 32'h55AA_55AA);
    busWrite(F_W, 32'h3FC, 32'hA5A5_0001);
    readCheck("lw.last", F_W, 32'h3FC, 32'hA5A5_0001, 1'b0);

    applyStimulus(1'b1, F_W, 32'h11, 32'hDEAD_BEEF);
    checkOutput("sw.mis.err",   {31'b0, busErr}, 32'h1);
    checkOutput("sw.mis.rdata", busRData, 32'h0);
    tick();
    busWe = 1'b0;
    readCheck("sw.mis.ram", F_W, 32'h10, 32'hAB22_BEEF, 1'b0);
    readCheck("lh.odd",   F_H,   32'h13,        32'h0, 1'b1);
    readCheck("lw.unmap", F_W,   32'h2000_0000, 32'h0, 1'b1);
    readCheck("lw.ramend", F_W,  32'h400,       32'h0, 1'b1);
    readCheck("f3.bad",   F_BAD, 32'h10,        32'h0, 1'b1);
    applyStimulus(1'b1, F_B, T_CTRL, 32'h0000_0007);
    checkOutput("sb.tmr.err",   {31'b0, busErr}, 32'h1);
    checkOutput("sb.tmr.rdata", busRData, 32'h0);
    tick();
    busWe = 1'b0;
    readCheck("sb.tmr.ctrl", F_W, T_CTRL, 32'h0, 1'b0);

    // Match at COUNT==5 with auto-reload and interrupt enabled
    busWrite(F_W, T_COMPARE, 32'd5);
    busWrite(F_W, T_CTRL, 32'h7);
    readCheck("tmr.start", F_W, T_COUNT, 32'd0, 1'b0);
    repeat (5) tick();
    readCheck("tmr.at5", F_W, T_COUNT, 32'd5, 1'b0);
    readCheck("tmr.at5.status", F_W, T_STATUS, 32'd0, 1'b0);
    checkOutput("tmr.at5.irq", {31'b0, timerIrq}, 32'h0);
    tick();
    readCheck("tmr.hit.status", F_W, T_STATUS, 32'd1, 1'b0);
    checkOutput("tmr.hit.irq", {31'b0, timerIrq}, 32'h1);
    readCheck("tmr.reload", F_W, T_COUNT, 32'd0, 1'b0);
    tick();
    readCheck("tmr.after", F_W, T_COUNT, 32'd1, 1'b0);
    busWrite(F_W, T_STATUS, 32'h1);
    checkOutput("tmr.w1c.irq", {31'b0, timerIrq}, 32'h0);
    readCheck("tmr.w1c.status", F_W, T_STATUS, 32'd0, 1'b0);

    // Software COUNT write priority and hardware-set-beats-W1C
    busWrite(F_W, T_CTRL, 32'h1);
    busWrite(F_W, T_COUNT, 32'd100);
    readCheck("cnt.wr", F_W, T_COUNT, 32'd100, 1'b0);
    tick();
    readCheck("cnt.inc", F_W, T_COUNT, 32'd101, 1'b0);
    busWrite(F_W, T_COMPARE, 32'd103);
    tick();
    readCheck("cnt.match", F_W, T_COUNT, 32'd103, 1'b0);
    busWrite(F_W, T_STATUS, 32'h1);
    readCheck("w1c.race.status", F_W, T_STATUS, 32'd1, 1'b0);
    readCheck("noreload.count", F_W, T_COUNT, 32'd104, 1'b0);

    busWrite(F_W, T_CTRL, 32'h7);
    checkOutput("pre.rst.irq", {31'b0, timerIrq}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async.irq", {31'b0, timerIrq}, 32'h0);
    readCheck("async.count",   F_W, T_COUNT,   32'd0,         1'b0);
    readCheck("async.compare", F_W, T_COMPARE, 32'hFFFF_FFFF, 1'b0);
    readCheck("async.ctrl",    F_W, T_CTRL,    32'd0,         1'b0);
    busWrite(F_W, 32'h20, 32'h1234_5678);
    reset = 1'b0;
    repeat (3) tick();
    readCheck("post.rst.count", F_W, T_COUNT, 32'd0, 1'b0);
    readCheck("ram.keep.10",    F_W, 32'h10,  32'hAB22_BEEF, 1'b0);
    readCheck("ram.blocked.20", F_W, 32'h20,  32'h55AA_55AA, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
